// File: rtl/kb_scan_ctrl_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
// Holds the FSM state enum, matrix geometry and the column priority helper.
package kb_pkg;

    localparam int KB_ROWS   = 4;
    localparam int KB_COLS   = 4;
    localparam int KB_CODE_W = 4;
    localparam int KB_COL_W  = $clog2(KB_COLS);

    localparam logic [KB_COLS-1:0] COL_IDLE = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } kb_state_t;

    // Lowest-index low column wins when several are pressed.
    function automatic logic [KB_COL_W-1:0] col_pick(input logic [KB_COLS-1:0] col);
        col_pick = '0;
        for (int i = KB_COLS - 1; i >= 0; i--) begin
            if (!col[i]) col_pick = KB_COL_W'(i);
        end
    endfunction

endpackage

// File: rtl/kb_scan_ctrl_tick_gen.sv
// Scan tick divider: one-cycle tick every SCAN_DIV clocks.
// Counter starts at zero, so the first tick lands SCAN_DIV cycles after reset.
module kb_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/kb_scan_ctrl.sv
// 4x4 keypad scanner with press/release debounce and a one-cycle key strobe.
// Optional auto-repeat while held: define KB_AUTOREPEAT_EN.
module kb_scan_ctrl
    import kb_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KB_COLS-1:0]   K_COL,
    output logic [KB_ROWS-1:0]   K_ROW,
    output logic [KB_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_held
);

    localparam int RW = $clog2(KB_ROWS);
    localparam int NW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [NW-1:0] DEB_LAST = NW'(DEBOUNCE_CNT);
    localparam logic [NW-1:0] DEB_ONE  = NW'(1);

    if (SCAN_DIV < 2) begin : g_bad_div
        $error("kb_scan_ctrl: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_deb
        $error("kb_scan_ctrl: DEBOUNCE_CNT must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
        $error("kb_scan_ctrl: repeat periods must be >= 1");
    end

    kb_state_t           state;
    logic [RW-1:0]       row;
    logic [KB_COL_W-1:0] col;
    logic [KB_COL_W-1:0] pick;
    logic [NW-1:0]       cnt;
    logic [NW-1:0]       cnt_inc;
    logic [KB_COLS-1:0]  col_m;
    logic [KB_COLS-1:0]  col_s;
    logic                tick;

`ifdef KB_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int PW = $clog2(RPT_MAX + 1);
    localparam logic [PW-1:0] RPT_FIRST = PW'(REPEAT_DELAY);
    localparam logic [PW-1:0] RPT_NEXT  = PW'(REPEAT_RATE);

    logic [PW-1:0] rpt;
    logic [PW-1:0] rpt_inc;
    logic          rpt_armed;

    assign rpt_inc = rpt + 1'b1;
`endif

    kb_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= COL_IDLE;
            col_s <= COL_IDLE;
        end else begin
            col_m <= K_COL;
            col_s <= col_m;
        end
    end

    assign pick    = col_pick(col_s);
    assign cnt_inc = cnt + 1'b1;
    assign K_ROW   = ~(4'b0001 << row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KB_AUTOREPEAT_EN
            rpt       <= '0;
            rpt_armed <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (col_s == COL_IDLE) begin
                            row <= row + 1'b1;
                        end else begin
                            col <= pick;
                            if (DEB_LAST == DEB_ONE) begin
                                key_code  <= {row, pick};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= HOLD;
                            end else begin
                                cnt   <= DEB_ONE;
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!col_s[col]) begin
                            if (cnt_inc == DEB_LAST) begin
                                key_code  <= {row, col};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= HOLD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt   <= '0;
                            row   <= row + 1'b1;
                            state <= SCAN;
                        end
                    end
                    HOLD: begin
                        // Only the latched column matters; others are ignored.
                        if (col_s[col]) begin
                            if (cnt_inc == DEB_LAST) begin
                                key_held  <= 1'b0;
                                cnt       <= '0;
                                row       <= row + 1'b1;
                                state     <= SCAN;
`ifdef KB_AUTOREPEAT_EN
                                rpt       <= '0;
                                rpt_armed <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= '0;
`ifdef KB_AUTOREPEAT_EN
                            if (rpt_inc == (rpt_armed ? RPT_NEXT : RPT_FIRST)) begin
                                key_valid <= 1'b1;
                                rpt       <= '0;
                                rpt_armed <= 1'b1;
                            end else begin
                                rpt <= rpt_inc;
                            end
`endif
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/kb_scan_ctrl.md
Name: kb_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. Drives the active-low row lines one at a time and samples the active-low column lines. Debounces press and release, then emits a registered 4-bit key code with a one-cycle valid strobe. It sits between the keypad pins and the display/datapath logic that consumes key codes.

Parameters:
SCAN_DIV, 50000, clk cycles per row dwell; the scan tick period; minimum 2.
DEBOUNCE_CNT, 4, consecutive stable ticks needed to accept a press or a release; minimum 1.
REPEAT_DELAY, 64, ticks in HOLD before the first auto-repeat; used only with KB_AUTOREPEAT_EN.
REPEAT_RATE, 16, ticks between auto-repeats; used only with KB_AUTOREPEAT_EN.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, asynchronous assert, active-low
K_COL  input  4  keypad column lines, active-low, asynchronous to clk
K_ROW  output  4  keypad row drive, one-hot active-low
key_code  output  4  row*4 + col of the accepted key; holds its value until the next accept
key_valid  output  1  one-cycle strobe when key_code is updated
key_held  output  1  high while an accepted key is still pressed

Behaviour:
- Reset values:
  - K_ROW = 4'b1110 (row 0), row index = 0, key_code = 0, key_valid = 0, key_held = 0.
  - state = SCAN; tick, debounce and repeat counters = 0.
- Synchronizer and tick:
  - K_COL passes through a 2-flop synchronizer; all decisions use the synchronized value col_s.
  - A tick pulses for one cycle every SCAN_DIV cycles. col_s is evaluated only on tick cycles.
- Column priority: if several bits of col_s are low, the lowest index wins. This gives the col value 0..3.
- K_ROW = ~(4'b0001 << row) at all times.
- States:
  - SCAN: on tick with col_s == 4'hF, row increments and wraps 3 -> 0. On tick with any col_s bit low, latch row/col, set debounce count = 1, go DEBOUNCE. The row stays frozen.
  - DEBOUNCE: on each tick, if col_s[latched col] == 0 the count increments; otherwise go SCAN and advance row by 1. The count check runs in the same cycle: when the count reaches DEBOUNCE_CNT, go HOLD. In the next cycle, key_code = {row, col}, key_valid = 1 for exactly one cycle, and key_held = 1. With DEBOUNCE_CNT = 1, acceptance happens on the detect tick itself.
  - HOLD: the row stays frozen. On each tick, if col_s[latched col] == 1 the release count increments; if it is 0 the count clears. When the release count reaches DEBOUNCE_CNT: key_held = 0, row advances by 1, go SCAN.
- Other boundary rules:
  - A different column going low during HOLD is ignored.
  - key_valid never asserts outside the DEBOUNCE -> HOLD edge, except for auto-repeat.
  - rst_n low in any state returns every output to its reset value immediately. No strobe is generated on reset release.
- Latency from a stable press to key_valid: (DEBOUNCE_CNT - 1) ticks after the detect tick, plus 1 cycle. The 2 synchronizer cycles add to the input side.

Optional Feature:
KB_AUTOREPEAT_EN
- Defined: in HOLD, a repeat counter counts ticks while the key stays pressed (release count = 0).
  - At REPEAT_DELAY ticks, key_valid pulses with the same key_code.
  - After that, key_valid pulses every REPEAT_RATE ticks.
  - Leaving HOLD clears the counter.
- Undefined: no repeat counter exists; exactly one key_valid per accepted press.

Decomposition:
- Package kb_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HOLD);
  - constants KB_ROWS = 4, KB_COLS = 4, KB_CODE_W = 4;
  - the idle column constant 4'hF.
- One sub-module: kb_tick_gen. It is a SCAN_DIV divider producing the one-cycle tick, with an asynchronous active-low reset.

Test Plan:
- Use SCAN_DIV = 4 and DEBOUNCE_CNT = 3 unless stated otherwise.
- Idle, K_COL = 4'hF for 40 cycles -> K_ROW cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid stays 0.
- Press row 2 col 1 (K_COL[1] = 0 while K_ROW = 1011) and hold -> row freezes at 1011; key_code = 4'd9 with one key_valid pulse about 2 ticks after detect; key_held = 1.
- Bounce: col 1 low for 1 tick, then high -> no key_valid; return to SCAN with K_ROW = 0111.
- Row 1 with K_COL = 4'b0110 (cols 0 and 3 low) -> key_code = 4'd4.
- Release with a glitch: high 2 ticks, low 1 tick, high 3 ticks -> key_held falls only after the final 3rd high tick.
- Reset mid-HOLD -> K_ROW = 1110, key_held = 0, key_code = 0 asynchronously.
- With KB_AUTOREPEAT_EN, REPEAT_DELAY = 8, REPEAT_RATE = 2, key held 14 ticks -> pulses at accept, then at +8, +10, +12, +14 ticks.
